uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; grant/ack one cycle after an IDLE request, requests held off while the UART is busy.
// Optional 16-bit frame counter port frame_count_o when UART_TX_ARB_STATS_EN is defined.
module uart_tx_arbiter #(
  parameter int REQUESTERS = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [REQUESTERS-1:0]   req_i,
  input  logic [8*REQUESTERS-1:0] data_i,
  output logic [REQUESTERS-1:0]   ack_o,
  output logic [REQUESTERS-1:0]   done_o,
  output logic [REQUESTERS-1:0]   grant_o,
  output logic                    busy_o,
  input  logic                    two_stop_bits_i,
  input  logic                    parity_bit_i,
  input  logic                    parity_even_i,
  input  logic [15:0]             clock_divider_i,
  output logic                    uart_write_o,
  output logic [7:0]              uart_data_o,
  output logic                    uart_two_stop_bits_o,
  output logic                    uart_parity_bit_o,
  output logic                    uart_parity_even_o,
  output logic [15:0]             uart_clock_divider_o,
  input  logic                    uart_busy_i
`ifdef UART_TX_ARB_STATS_EN
  ,
  output logic [15:0]             frame_count_o
`endif
);

  localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {RESET_WAIT, IDLE, START, SEND} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      win_idx;
  logic [REQUESTERS-1:0] win_oh;
  logic [CW-1:0]         cand;
  logic                  found;
  logic                  take;
  logic                  finish;

  // Search from ptr upward with wrap; cand carries one spare bit so ptr+k never overflows.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(REQUESTERS)) cand = cand - CW'(REQUESTERS);
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= RESET_WAIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    finish    = 1'b0;
    case (state)
      RESET_WAIT: if (!uart_busy_i) state_nxt = IDLE;
      IDLE: begin
        if (found && !uart_busy_i) begin
          take      = 1'b1;
          state_nxt = START;
        end
      end
      START: if (uart_busy_i) state_nxt = SEND;
      SEND: begin
        if (!uart_busy_i) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = RESET_WAIT;
    endcase
  end

  assign busy_o = (state != IDLE);

  // Frame data and configuration are captured only at grant, so input changes mid-frame are ignored.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ack_o                <= '0;
      done_o               <= '0;
      grant_o              <= '0;
      ptr                  <= '0;
      uart_write_o         <= 1'b0;
      uart_data_o          <= 8'h00;
      uart_two_stop_bits_o <= 1'b0;
      uart_parity_bit_o    <= 1'b0;
      uart_parity_even_o   <= 1'b0;
      uart_clock_divider_o <= 16'h0000;
    end else begin
      ack_o  <= '0;
      done_o <= '0;
      if (take) begin
        ack_o                <= win_oh;
        grant_o              <= win_oh;
        ptr                  <= (win_idx == IDX_W'(REQUESTERS - 1)) ? '0 : win_idx + IDX_W'(1);
        uart_write_o         <= 1'b1;
        uart_data_o          <= data_i[8*win_idx +: 8];
        uart_two_stop_bits_o <= two_stop_bits_i;
        uart_parity_bit_o    <= parity_bit_i;
        uart_parity_even_o   <= parity_even_i;
        uart_clock_divider_o <= clock_divider_i;
      end
      if (state == START && uart_busy_i) uart_write_o <= 1'b0;
      if (finish) begin
        done_o  <= grant_o;
        grant_o <= '0;
      end
    end
  end

`ifdef UART_TX_ARB_STATS_EN
  always_ff @(posedge clock_i) begin
    if (reset_i)     frame_count_o <= 16'h0000;
    else if (finish) frame_count_o <= frame_count_o + 16'h0001;
  end
`endif

endmodule
